wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, SHALL select round-robin arbitration (1) or fixed priority scalu > scmul > lsq (0).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-004 For each unit U in {scalu, scmul, lsq}: U_valid  input  1  result offered.
REQ-005 U_error  input  1; U_ecause  input  5; U_robid  input  7; U_rd  input  6; U_result  input  32  payload, held stable by U while stalled.
REQ-006 wb_U_stall  output  1  U's result not accepted this cycle; U SHALL hold valid and payload.
REQ-007 wb_valid  output  1  registered writeback broadcast to ROB and reservation stations.
REQ-008 wb_error  output  1; wb_ecause  output  5; wb_robid  output  7; wb_rd  output  6; wb_result  output  32  registered broadcast payload.
REQ-009 rob_wb_stall  input  1  ROB cannot accept the broadcast this cycle.
REQ-010 rob_flush  input  1  pipeline flush; discards all in-flight results.

Function
REQ-011 The block SHALL hold a one-entry output register (wb_valid plus payload) and a 2-bit round-robin pointer ptr in {0=scalu,1=scmul,2=lsq}.
REQ-012 Output register "free" SHALL be: ~wb_valid | ~rob_wb_stall.
REQ-013 When free and ~rob_flush, exactly one valid requester SHALL be granted, combinationally, in the same cycle.
REQ-014 RR_EN=1: the grant SHALL go to the first valid unit starting at ptr, searching in order ptr, ptr+1, ptr+2 modulo 3.
REQ-015 RR_EN=0: the grant SHALL go to the highest-priority valid unit; ptr SHALL be ignored.
REQ-016 wb_U_stall SHALL equal U_valid & ~grant_U; it SHALL never be asserted while U_valid=0.
REQ-017 On a grant, the granted payload SHALL load into the output register at the next edge with wb_valid=1 (latency 1 cycle, U_valid to wb_valid).
REQ-018 On a grant, ptr SHALL advance to (granted index + 1) modulo 3; the value 3 SHALL never be reached.
REQ-019 When free and no unit is valid, wb_valid SHALL become 0 at the next edge and ptr SHALL hold.
REQ-020 When not free (wb_valid=1 & rob_wb_stall=1), the output register and ptr SHALL hold, and every valid unit SHALL see stall=1.
REQ-021 A result SHALL appear on wb_valid exactly once; none may be dropped or duplicated absent flush.
REQ-022 rob_flush=1 SHALL clear wb_valid at the next edge regardless of rob_wb_stall, SHALL grant nothing, and SHALL force all wb_U_stall to 0.
REQ-023 rob_flush SHALL leave ptr unchanged.
REQ-024 Payload registers SHALL load only on a grant; when wb_valid=0 their contents are don't-care.
REQ-025 With RR_EN=1 and all three units continuously valid, grants SHALL cycle scalu, scmul, lsq, scalu, ... with no unit waiting more than 2 grants.

Reset
REQ-026 While rst=0 at an edge: wb_valid SHALL be 0, ptr SHALL be 0, and wb_error, wb_ecause, wb_robid, wb_rd and wb_result SHALL be 0.
REQ-027 Reset SHALL take priority over rob_flush and grants; a result offered during reset SHALL not be captured, and its stall output is don't-care.
REQ-028 From the first edge with rst=1 the block SHALL arbitrate normally, with ptr=0.

Verification
REQ-029 Single result: after reset, scalu_valid=1, robid=7'h05, rd=6'h03, result=32'hDEADBEEF for one cycle -> wb_scalu_stall=0; next cycle wb_valid=1 carrying that payload; the cycle after, wb_valid=0.
REQ-030 Round-robin with all three valid and held, RR_EN=1, ptr=0 -> grants scalu, scmul, lsq on consecutive cycles; stalls: cycle 1 scmul=1 and lsq=1, cycle 2 lsq=1, cycle 3 none.
REQ-031 Backpressure: wb_valid=1 and rob_wb_stall=1 for 3 cycles with scmul_valid=1 -> wb_scmul_stall=1 and output held for 3 cycles; scmul is captured in the cycle rob_wb_stall drops.
REQ-032 Flush: wb_valid=1, rob_wb_stall=1, lsq_valid=1, then rob_flush=1 -> all stalls 0 that cycle; wb_valid=0 next cycle; ptr unchanged.
REQ-033 Fixed priority: RR_EN=0 with scmul and lsq valid for 2 cycles -> scmul granted both cycles; lsq stalled both cycles.
REQ-034 Reset mid-operation: rst=0 while wb_valid=1 and scalu_valid=1 -> wb_valid=0 and all payload outputs 0 next cycle; after release, the first grant follows from ptr=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges scalu/scmul/lsq results into one registered
// broadcast, using round-robin or fixed-priority arbitration.
module wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        scalu_valid,
    input  logic        scalu_error,
    input  logic [4:0]  scalu_ecause,
    input  logic [6:0]  scalu_robid,
    input  logic [5:0]  scalu_rd,
    input  logic [31:0] scalu_result,
    output logic        wb_scalu_stall,

    input  logic        scmul_valid,
    input  logic        scmul_error,
    input  logic [4:0]  scmul_ecause,
    input  logic [6:0]  scmul_robid,
    input  logic [5:0]  scmul_rd,
    input  logic [31:0] scmul_result,
    output logic        wb_scmul_stall,

    input  logic        lsq_valid,
    input  logic        lsq_error,
    input  logic [4:0]  lsq_ecause,
    input  logic [6:0]  lsq_robid,
    input  logic [5:0]  lsq_rd,
    input  logic [31:0] lsq_result,
    output logic        wb_lsq_stall,

    output logic        wb_valid,
    output logic        wb_error,
    output logic [4:0]  wb_ecause,
    output logic [6:0]  wb_robid,
    output logic [5:0]  wb_rd,
    output logic [31:0] wb_result,

    input  logic        rob_wb_stall,
    input  logic        rob_flush
);

    typedef enum logic [1:0] {
        PTR_SCALU = 2'd0,
        PTR_SCMUL = 2'd1,
        PTR_LSQ   = 2'd2
    } ptr_t;

    ptr_t        r_ptr;
    logic        r_wb_valid;
    logic        r_wb_error;
    logic [4:0]  r_wb_ecause;
    logic [6:0]  r_wb_robid;
    logic [5:0]  r_wb_rd;
    logic [31:0] r_wb_result;

    logic [2:0]  w_req;
    logic        w_free;
    logic        w_arb_en;
    logic        w_any_grant;
    logic [1:0]  w_start;
    logic [1:0]  w_gidx;
    logic [2:0]  w_grant;
    ptr_t        w_ptr_next;

    logic        w_sel_error;
    logic [4:0]  w_sel_ecause;
    logic [6:0]  w_sel_robid;
    logic [5:0]  w_sel_rd;
    logic [31:0] w_sel_result;

    // First requester found scanning upward (mod 3) from index s.
    function automatic logic [1:0] first_from(input logic [2:0] req, input logic [1:0] s);
        logic [1:0] idx;
        case (s)
            2'd1: begin
                if (req[1])      idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else             idx = 2'd0;
            end
            2'd2: begin
                if (req[2])      idx = 2'd2;
                else if (req[0]) idx = 2'd0;
                else             idx = 2'd1;
            end
            default: begin
                if (req[0])      idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else             idx = 2'd2;
            end
        endcase
        return idx;
    endfunction

    assign w_req       = {lsq_valid, scmul_valid, scalu_valid};
    assign w_free      = ~r_wb_valid | ~rob_wb_stall;
    assign w_arb_en    = w_free & ~rob_flush;
    assign w_any_grant = w_arb_en & (|w_req);
    assign w_start     = (RR_EN != 0) ? r_ptr : PTR_SCALU;
    assign w_gidx      = first_from(w_req, w_start);

    always_comb begin
        w_grant    = '0;
        w_ptr_next = r_ptr;
        if (w_any_grant) begin
            w_grant[w_gidx] = 1'b1;
            case (w_gidx)
                2'd0:    w_ptr_next = PTR_SCMUL;
                2'd1:    w_ptr_next = PTR_LSQ;
                default: w_ptr_next = PTR_SCALU;
            endcase
        end
    end

    always_comb begin
        w_sel_error  = scalu_error;
        w_sel_ecause = scalu_ecause;
        w_sel_robid  = scalu_robid;
        w_sel_rd     = scalu_rd;
        w_sel_result = scalu_result;
        case (w_gidx)
            2'd1: begin
                w_sel_error  = scmul_error;
                w_sel_ecause = scmul_ecause;
                w_sel_robid  = scmul_robid;
                w_sel_rd     = scmul_rd;
                w_sel_result = scmul_result;
            end
            2'd2: begin
                w_sel_error  = lsq_error;
                w_sel_ecause = lsq_ecause;
                w_sel_robid  = lsq_robid;
                w_sel_rd     = lsq_rd;
                w_sel_result = lsq_result;
            end
            default: ;
        endcase
    end

    // Flush masks stalls so producers can drop their in-flight results.
    assign wb_scalu_stall = scalu_valid & ~w_grant[0] & ~rob_flush;
    assign wb_scmul_stall = scmul_valid & ~w_grant[1] & ~rob_flush;
    assign wb_lsq_stall   = lsq_valid   & ~w_grant[2] & ~rob_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= PTR_SCALU;
            r_wb_valid  <= 1'b0;
            r_wb_error  <= 1'b0;
            r_wb_ecause <= '0;
            r_wb_robid  <= '0;
            r_wb_rd     <= '0;
            r_wb_result <= '0;
        end else if (rob_flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_free) begin
            r_wb_valid <= w_any_grant;
            if (w_any_grant) begin
                r_ptr       <= w_ptr_next;
                r_wb_error  <= w_sel_error;
                r_wb_ecause <= w_sel_ecause;
                r_wb_robid  <= w_sel_robid;
                r_wb_rd     <= w_sel_rd;
                r_wb_result <= w_sel_result;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_error  = r_wb_error;
    assign wb_ecause = r_wb_ecause;
    assign wb_robid  = r_wb_robid;
    assign wb_rd     = r_wb_rd;
    assign wb_result = r_wb_result;

endmodule
